pe_dot_accum: RTL and testbench

PE_DOT_ACCUM -- requirements
Module: pe_dot_accum

---
 rtl/pe_dot_accum_pkg.sv | 33 +++
 rtl/pe_accum_fifo.sv | 63 ++++++
 rtl/pe_dot_accum.sv | 127 ++++++++++++
 tb/tb_pe_dot_accum.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/pe_dot_accum_pkg.sv
// Shared types for the dot-product accumulation stage: configuration record,
// accumulator FSM states and the buffered result entry.
package pe_types;

  typedef struct packed {
    int NUM_FEATURES;
    int NUM_FILTERS;
    int DOT_OUTPUT_WIDTH;
  } pe_cfg_t;

  localparam int PE_NUM_FEATURES = 2;
  localparam int PE_NUM_FILTERS  = 2;
  localparam int PE_DOT_WIDTH    = 16;
  localparam int PE_ACCUM_WIDTH  = 32;

  localparam pe_cfg_t PE_CFG_DEFAULT = '{
    NUM_FEATURES:     PE_NUM_FEATURES,
    NUM_FILTERS:      PE_NUM_FILTERS,
    DOT_OUTPUT_WIDTH: PE_DOT_WIDTH
  };

  typedef enum logic {
    ACC_IDLE  = 1'b0,
    ACC_ACCUM = 1'b1
  } acc_state_e;

  // Buffered result for the default geometry: saturation flag plus sums.
  typedef struct packed {
    logic                                                            sat;
    logic [PE_NUM_FEATURES-1:0][PE_NUM_FILTERS-1:0][PE_ACCUM_WIDTH-1:0] data;
  } accum_entry_t;

endpackage

// File: rtl/pe_accum_fifo.sv
// Two-entry result buffer. A push into a full buffer is accepted only when a
// pop happens in the same cycle; otherwise it is dropped and flagged.
module pe_accum_fifo #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             head_valid,
  output logic [WIDTH-1:0] head_data,
  output logic             drop
);

  logic [1:0][WIDTH-1:0] mem_q, mem_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            count_q, count_d;
  logic                  full, pop_ok, push_ok;

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    full     = (count_q == 2'd2);
    pop_ok   = pop && (count_q != 2'd0);
    push_ok  = push && (!full || pop_ok);
    drop     = push && !push_ok;
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop_ok) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      // NOTE: the two storage slots are reset as well, so the head reads
      // zero rather than stale data while the buffer is empty.
      mem_q    <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_valid = (count_q != 2'd0);
  assign head_data  = mem_q[rd_ptr_q];

endmodule

// File: rtl/pe_dot_accum.sv
// Accumulates signed dot-product beats per [feature][filter] element with
// saturation and hands finished sums to a two-entry output buffer.
module pe_dot_accum
  import pe_types::*;
#(
  parameter pe_cfg_t cfg         = PE_CFG_DEFAULT,
  parameter int      ACCUM_WIDTH = 32
) (
  input  logic clock,
  input  logic resetn,
  input  logic i_valid,
  input  logic i_first,
  input  logic i_last,
  input  logic [cfg.NUM_FEATURES-1:0][cfg.NUM_FILTERS-1:0][cfg.DOT_OUTPUT_WIDTH-1:0] i_dot_result,
  output logic o_valid,
  input  logic i_ready,
  output logic [cfg.NUM_FEATURES-1:0][cfg.NUM_FILTERS-1:0][ACCUM_WIDTH-1:0] o_accum,
  output logic o_sat,
  output logic o_error
);

  localparam int NF     = cfg.NUM_FEATURES;
  localparam int NM     = cfg.NUM_FILTERS;
  localparam int AW     = ACCUM_WIDTH;
  localparam int DATA_W = NF * NM * AW;

  localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

  if (ACCUM_WIDTH < cfg.DOT_OUTPUT_WIDTH) begin : g_width_check
    $fatal(1, "pe_dot_accum: ACCUM_WIDTH must be >= DOT_OUTPUT_WIDTH");
  end

  typedef logic [NF-1:0][NM-1:0][AW-1:0] acc_arr_t;

  acc_state_e       state_q, state_d;
  acc_arr_t         acc_q, acc_d;
  acc_arr_t         dot_ext, add_res, push_data;
  logic [NF*NM-1:0] add_sat;
  logic             sat_q, sat_d;
  logic             err_q, err_d;
  logic             push, push_sat, proto_err, fifo_drop, pop;
  logic [DATA_W:0]  head_entry;

  // One extra sum bit per element exposes overflow: the top two bits differ.
  for (genvar f = 0; f < NF; f++) begin : g_feat
    for (genvar m = 0; m < NM; m++) begin : g_filt
      logic [AW:0] sum_wide;
      assign dot_ext[f][m]     = AW'($signed(i_dot_result[f][m]));
      assign sum_wide          = {acc_q[f][m][AW-1], acc_q[f][m]}
                               + {dot_ext[f][m][AW-1], dot_ext[f][m]};
      assign add_sat[f*NM + m] = sum_wide[AW] ^ sum_wide[AW-1];
      assign add_res[f][m]     = add_sat[f*NM + m] ? (sum_wide[AW] ? ACC_MIN : ACC_MAX)
                                                   : sum_wide[AW-1:0];
    end
  end

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    sat_d     = sat_q;
    push      = 1'b0;
    push_data = add_res;
    push_sat  = sat_q | (|add_sat);
    proto_err = 1'b0;
    if (i_valid) begin
      if (i_first) begin
        // A first beat mid-accumulation abandons the old sums and restarts.
        proto_err = (state_q == ACC_ACCUM);
        acc_d     = dot_ext;
        sat_d     = 1'b0;
        if (i_last) begin
          push      = 1'b1;
          push_data = dot_ext;
          push_sat  = 1'b0;
          state_d   = ACC_IDLE;
        end else begin
          state_d = ACC_ACCUM;
        end
      end else if (state_q == ACC_IDLE) begin
        proto_err = 1'b1;
      end else begin
        acc_d = add_res;
        sat_d = sat_q | (|add_sat);
        if (i_last) begin
          push    = 1'b1;
          state_d = ACC_IDLE;
        end
      end
    end
  end

  assign err_d = err_q | proto_err | fifo_drop;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ACC_IDLE;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      err_q   <= err_d;
    end
  end

  assign pop = o_valid && i_ready;

  pe_accum_fifo #(
    .WIDTH(DATA_W + 1)
  ) u_fifo (
    .clock      (clock),
    .resetn     (resetn),
    .push       (push),
    .push_data  ({push_sat, push_data}),
    .pop        (pop),
    .head_valid (o_valid),
    .head_data  (head_entry),
    .drop       (fifo_drop)
  );

  assign {o_sat, o_accum} = head_entry;
  assign o_error          = err_q;

endmodule

// File: tb/tb_pe_dot_accum.sv
// Self-checking bench: table-driven beats on a 32-bit accumulator with a
// scoreboard of expected buffer entries, plus a 16-bit instance for saturation.
module tb_pe_dot_accum;
  import pe_types::*;

  localparam int NF = PE_NUM_FEATURES;
  localparam int NM = PE_NUM_FILTERS;
  localparam int DW = PE_DOT_WIDTH;

  typedef logic [NF-1:0][NM-1:0][DW-1:0] dot_t;

  typedef struct {
    bit v, f, l, rdy;
    int base;
    bit push;
    int exp;
    int n;
    bit err;
  } vec_t;

  logic clock  = 1'b0;
  logic resetn = 1'b1;
  always #5 clock = ~clock;

  logic i_valid = 1'b0, i_first = 1'b0, i_last = 1'b0, i_ready = 1'b0;
  dot_t i_dot_result = '0;
  logic o_valid, o_sat, o_error;
  logic [NF-1:0][NM-1:0][PE_ACCUM_WIDTH-1:0] o_accum;

  logic v16 = 1'b0, f16 = 1'b0, l16 = 1'b0, r16 = 1'b1;
  dot_t dot16 = '0;
  logic ov16, sat16, err16;
  logic [NF-1:0][NM-1:0][15:0] acc16;

  pe_dot_accum #(.cfg(PE_CFG_DEFAULT), .ACCUM_WIDTH(PE_ACCUM_WIDTH)) u_dut (
    .clock(clock), .resetn(resetn), .i_valid(i_valid), .i_first(i_first),
    .i_last(i_last), .i_dot_result(i_dot_result), .o_valid(o_valid),
    .i_ready(i_ready), .o_accum(o_accum), .o_sat(o_sat), .o_error(o_error)
  );

  pe_dot_accum #(.cfg(PE_CFG_DEFAULT), .ACCUM_WIDTH(16)) u_dut16 (
    .clock(clock), .resetn(resetn), .i_valid(v16), .i_first(f16),
    .i_last(l16), .i_dot_result(dot16), .o_valid(ov16),
    .i_ready(r16), .o_accum(acc16), .o_sat(sat16), .o_error(err16)
  );

  int checks   = 0;
  int failures = 0;
  accum_entry_t exp_q[$];
  vec_t tbl[13];

  task automatic check(string name, logic signed [63:0] act, logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Element k = f*NM+m carries base+k, so every element differs.
  function automatic dot_t mk_dot(int base);
    dot_t d;
    for (int f = 0; f < NF; f++)
      for (int m = 0; m < NM; m++)
        d[f][m] = DW'(base + f*NM + m);
    return d;
  endfunction

  // n beats each adding k to element k give exp + k*n.
  function automatic accum_entry_t mk_entry(int exp, int n, bit sat);
    accum_entry_t e;
    e.sat = sat;
    for (int f = 0; f < NF; f++)
      for (int m = 0; m < NM; m++)
        e.data[f][m] = PE_ACCUM_WIDTH'(exp + (f*NM + m)*n);
    return e;
  endfunction

  task automatic cycle(bit v, bit f, bit l, bit rdy, int base, bit push,
                       int exp, int n, bit exp_err, string tag);
    i_valid      = v;
    i_first      = f;
    i_last       = l;
    i_ready      = rdy;
    i_dot_result = mk_dot(base);
    if (rdy && exp_q.size() > 0) begin
      accum_entry_t e;
      e = exp_q.pop_front();
      check({tag, "_head_valid"}, o_valid, 1);
      check({tag, "_head_sat"}, o_sat, e.sat);
      for (int ff = 0; ff < NF; ff++)
        for (int mm = 0; mm < NM; mm++)
          check($sformatf("%s_head_acc%0d", tag, ff*NM + mm),
                $signed(o_accum[ff][mm]), $signed(e.data[ff][mm]));
    end
    if (push) exp_q.push_back(mk_entry(exp, n, 1'b0));
    @(posedge clock);
    #1;
    check({tag, "_o_valid"}, o_valid, exp_q.size() > 0);
    check({tag, "_o_error"}, o_error, exp_err);
  endtask

  task automatic apply_reset(string tag);
    i_valid = 1'b0; i_first = 1'b0; i_last = 1'b0; i_ready = 1'b0;
    v16 = 1'b0; f16 = 1'b0; l16 = 1'b0;
    resetn = 1'b0;
    #1;
    check({tag, "_rst_valid"}, o_valid, 0);
    check({tag, "_rst_sat"}, o_sat, 0);
    check({tag, "_rst_error"}, o_error, 0);
    check({tag, "_rst_accum_nonzero"}, |o_accum, 0);
    check({tag, "_rst_valid16"}, ov16, 0);
    exp_q.delete();
    @(posedge clock);
    #1;
    resetn = 1'b1;
  endtask

  task automatic cycle16(bit v, bit f, bit l, int base);
    v16   = v;
    f16   = f;
    l16   = l;
    dot16 = mk_dot(base);
    @(posedge clock);
    #1;
  endtask

  task automatic run_sat16(int base, int exp_elem, bit exp_sat, int beats, bit same, string tag);
    for (int b = 0; b < beats; b++)
      cycle16(1'b1, b == 0, b == beats - 1, base);
    cycle16(1'b0, 1'b0, 1'b0, 0);
    // Sampled one cycle after the last beat, before the pop at the next edge.
    v16 = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl = '{
      '{1, 1, 1, 1,  -5, 1, -5, 1, 0},   // single beat
      '{0, 0, 0, 1,   0, 0,  0, 0, 0},
      '{1, 1, 0, 1, 100, 0,  0, 0, 0},   // 100, -30, gap, 7
      '{1, 0, 0, 1, -30, 0,  0, 0, 0},
      '{0, 0, 0, 1,   0, 0,  0, 0, 0},
      '{1, 0, 1, 1,   7, 1, 77, 3, 0},
      '{0, 0, 0, 1,   0, 0,  0, 0, 0},
      '{1, 1, 1, 0,   1, 1,  1, 1, 0},   // fill the buffer with ready low
      '{1, 1, 1, 0,   2, 1,  2, 1, 0},
      '{1, 1, 1, 0,   3, 0,  0, 0, 1},   // dropped
      '{0, 0, 0, 1,   0, 0,  0, 0, 1},
      '{0, 0, 0, 1,   0, 0,  0, 0, 1},
      '{0, 0, 0, 1,   0, 0,  0, 0, 1}
    };

    #3;
    apply_reset("init");

    for (int i = 0; i < $size(tbl); i++)
      cycle(tbl[i].v, tbl[i].f, tbl[i].l, tbl[i].rdy, tbl[i].base,
            tbl[i].push, tbl[i].exp, tbl[i].n, tbl[i].err, $sformatf("tbl%0d", i));

    // Full buffer with simultaneous push and pop: nothing dropped.
    apply_reset("pp");
    cycle(1, 1, 1, 0, 10, 1, 10, 1, 0, "pp_fill0");
    cycle(1, 1, 1, 0, 20, 1, 20, 1, 0, "pp_fill1");
    cycle(1, 1, 1, 1, 30, 1, 30, 1, 0, "pp_both");
    cycle(0, 0, 0, 1,  0, 0,  0, 0, 0, "pp_drain0");
    cycle(0, 0, 0, 1,  0, 0,  0, 0, 0, "pp_drain1");
    cycle(0, 0, 0, 1,  0, 0,  0, 0, 0, "pp_empty");

    // First beat in the middle of an accumulation restarts it.
    apply_reset("rs");
    cycle(1, 1, 0, 1, 40, 0,  0, 0, 0, "rs_start");
    cycle(1, 1, 0, 1, 60, 0,  0, 0, 1, "rs_restart");
    cycle(1, 0, 1, 1,  5, 1, 65, 2, 1, "rs_last");
    cycle(0, 0, 0, 1,  0, 0,  0, 0, 1, "rs_pop");

    // Stray beat in IDLE, then reset in the middle of an accumulation.
    apply_reset("ab");
    cycle(1, 1, 1, 0, 50, 1, 50, 1, 0, "ab_entry");
    cycle(1, 0, 0, 0,  7, 0,  0, 0, 1, "ab_stray");
    cycle(1, 1, 0, 0, 50, 0,  0, 0, 1, "ab_accum");
    apply_reset("ab_mid");
    cycle(1, 1, 0, 1,  9, 0,  0, 0, 0, "ab_clean0");
    cycle(1, 0, 1, 1,  1, 1, 10, 2, 0, "ab_clean1");
    cycle(0, 0, 0, 1,  0, 0,  0, 0, 0, "ab_pop");
    i_valid = 1'b0;

    // 16-bit accumulator: positive and negative saturation, then a clean sum.
    apply_reset("s16");
    r16 = 1'b1;
    for (int b = 0; b < 8; b++) cycle16(1'b1, b == 0, b == 7, 8000);
    check("s16_pos_valid", ov16, 1);
    check("s16_pos_sat", sat16, 1);
    for (int k = 0; k < NF*NM; k++)
      check($sformatf("s16_pos_acc%0d", k), $signed(acc16[k/NM][k%NM]), 32767);
    cycle16(1'b0, 1'b0, 1'b0, 0);
    for (int b = 0; b < 8; b++) cycle16(1'b1, b == 0, b == 7, -8000);
    check("s16_neg_sat", sat16, 1);
    for (int k = 0; k < NF*NM; k++)
      check($sformatf("s16_neg_acc%0d", k), $signed(acc16[k/NM][k%NM]), -32768);
    cycle16(1'b0, 1'b0, 1'b0, 0);
    cycle16(1'b1, 1'b1, 1'b0, 100);
    cycle16(1'b1, 1'b0, 1'b1, 100);
    check("s16_clean_sat", sat16, 0);
    for (int k = 0; k < NF*NM; k++)
      check($sformatf("s16_clean_acc%0d", k), $signed(acc16[k/NM][k%NM]), 200 + 2*k);
    cycle16(1'b0, 1'b0, 1'b0, 0);
    check("s16_drained", ov16, 0);
    check("s16_error", err16, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
